// File: rtl/gshare_branch_predictor_if.sv
// Decode/MEM-side signal bundle for the gshare branch predictor.
// master drives the lookup and training inputs; slave is the predictor.
interface gshare_branch_predictor_if;
    logic        actual_branch_decision;
    logic        branch_decode_sig;
    logic        branch_mem_sig;
    logic [31:0] pc_branch_addr;
    logic [31:0] offset;
    logic [31:0] update_branch_addr;
    logic [31:0] out_branch_addr;
    logic        prediction;
    logic        ready;

    modport master (
        output actual_branch_decision,
        output branch_decode_sig,
        output branch_mem_sig,
        output pc_branch_addr,
        output offset,
        output update_branch_addr,
        input  out_branch_addr,
        input  prediction,
        input  ready
    );

    modport slave (
        input  actual_branch_decision,
        input  branch_decode_sig,
        input  branch_mem_sig,
        input  pc_branch_addr,
        input  offset,
        input  update_branch_addr,
        output out_branch_addr,
        output prediction,
        output ready
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Saturating-counter branch direction predictor with an init sweep after reset.
// Define GSHARE_HISTORY_EN for gshare (global history XOR) indexing; otherwise pure bimodal.
module gshare_branch_predictor #(
    parameter int INDEX_BITS   = 4,
    parameter int COUNTER_BITS = 2,
    parameter int HISTORY_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    gshare_branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK = COUNTER_BITS'(1 << (COUNTER_BITS - 1));
    localparam logic [COUNTER_BITS-1:0] CTR_MAX  = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_reg;
    logic [INDEX_BITS-1:0]   init_idx_reg;
    logic                    ready_reg;
    logic                    branch_mem_sig_q;
    logic [COUNTER_BITS-1:0] ctr_reg [ENTRIES];

    logic [INDEX_BITS-1:0]   hist_ext;
    logic [INDEX_BITS-1:0]   idx_p;
    logic [INDEX_BITS-1:0]   idx_u;
    logic                    update_evt;
    logic [COUNTER_BITS-1:0] ctr_u;
    logic                    wr_en;
    logic [INDEX_BITS-1:0]   wr_idx;
    logic [COUNTER_BITS-1:0] wr_data;
    logic                    unused_bits;

    // Rising edge of the MEM flag so a stalled branch trains only once.
    assign update_evt = (state_reg == ST_RUN) && bp.branch_mem_sig && !branch_mem_sig_q;

`ifdef GSHARE_HISTORY_EN
    logic [HISTORY_BITS-1:0] ghr_reg;

    // Truncating {ghr, taken} keeps the newest HISTORY_BITS outcomes, including HISTORY_BITS=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_reg <= '0;
        end else if (update_evt) begin
            ghr_reg <= HISTORY_BITS'({ghr_reg, bp.actual_branch_decision});
        end
    end

    assign hist_ext = INDEX_BITS'(ghr_reg);
`else
    assign hist_ext = '0;
`endif

    assign idx_p = bp.pc_branch_addr[INDEX_BITS-1:0] ^ hist_ext;
    assign idx_u = bp.update_branch_addr[INDEX_BITS-1:0] ^ hist_ext;

    // Lookup reads the pre-update value; no bypass from the same-cycle write.
    assign bp.prediction      = ctr_reg[idx_p][COUNTER_BITS-1] & bp.branch_decode_sig & ready_reg;
    assign bp.ready           = ready_reg;
    assign bp.out_branch_addr = bp.pc_branch_addr + bp.offset;

    assign unused_bits = ^{bp.pc_branch_addr[31:INDEX_BITS],
                           bp.update_branch_addr[31:INDEX_BITS],
                           1'(HISTORY_BITS)};

    always_comb begin
        ctr_u   = ctr_reg[idx_u];
        wr_en   = 1'b0;
        wr_idx  = idx_u;
        wr_data = ctr_u;
        if (!reset) begin
            if (state_reg == ST_INIT) begin
                wr_en   = 1'b1;
                wr_idx  = init_idx_reg;
                wr_data = CTR_WEAK;
            end else if (update_evt) begin
                wr_en = 1'b1;
                if (bp.actual_branch_decision) begin
                    wr_data = (ctr_u == CTR_MAX) ? ctr_u : ctr_u + COUNTER_BITS'(1);
                end else begin
                    wr_data = (ctr_u == '0) ? ctr_u : ctr_u - COUNTER_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ctr_reg[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_INIT;
            init_idx_reg     <= '0;
            ready_reg        <= 1'b0;
            branch_mem_sig_q <= 1'b0;
        end else begin
            branch_mem_sig_q <= bp.branch_mem_sig;
            if (state_reg == ST_INIT) begin
                init_idx_reg <= init_idx_reg + INDEX_BITS'(1);
                if (init_idx_reg == INDEX_BITS'(ENTRIES - 1)) begin
                    ready_reg <= 1'b1;
                    state_reg <= ST_RUN;
                end
            end
        end
    end
endmodule
